mem_burst_responder: RTL and testbench

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

---
 rtl/mem_burst_responder.sv | 126 ++++++++++++
 tb/tb_mem_burst_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// Behavioural line-burst memory: accepts cache-line refill/writeback requests and,
// after a fixed wait, streams LINE_SIZE 32-bit words out of or into its storage.
`ifndef CACHE_B
`define CACHE_B 4
`endif

module mem_burst_responder #(
  parameter int OFFSET_WIDTH = `CACHE_B,
  parameter int MEM_AW       = 10,
  parameter int LATENCY      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  input  logic [31:0] wdata_i,
  input  logic        wdata_valid_i,
  output logic        wdata_ready_o,
  output logic        wack_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        rdata_last_o,
  input  logic        rdata_ready_i
);

  localparam int LINE_SIZE = 2 ** (OFFSET_WIDTH - 2);
  localparam int KW        = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [MEM_AW-1:0] LINE_MASK = ~MEM_AW'(LINE_SIZE - 1);
  localparam logic [KW-1:0]     LAST_BEAT = KW'(LINE_SIZE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, READ, WRITE} state_t;

  state_t            state_q;
  logic [3:0]        wait_cnt_q;
  logic [KW-1:0]     beat_q;
  logic [KW-1:0]     beat_nxt;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW-1:0] idx;
  logic [MEM_AW-1:0] idx_nxt;
  logic              write_q;
  logic              wr_en;

  logic [31:0] mem [0:(2**MEM_AW)-1];

  // Byte-offset and out-of-range address bits carry no information here.
  logic unused_addr;
  assign unused_addr = ^{req_addr_i[31:MEM_AW+2], req_addr_i[1:0]};

  assign beat_nxt = beat_q + KW'(1);
  assign idx      = base_q + MEM_AW'(beat_q);
  assign idx_nxt  = base_q + MEM_AW'(beat_nxt);

  assign req_ready_o   = (state_q == IDLE);
  assign wdata_ready_o = (state_q == WRITE);
  assign wr_en         = (state_q == WRITE) && wdata_valid_i;

  // Storage is deliberately outside the reset domain so words survive an aborted burst.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[idx] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      beat_q        <= '0;
      base_q        <= '0;
      write_q       <= 1'b0;
      wack_o        <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      rdata_last_o  <= 1'b0;
    end else begin
      wack_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            base_q     <= req_addr_i[MEM_AW+1:2] & LINE_MASK;
            write_q    <= req_write_i;
            wait_cnt_q <= 4'(LATENCY - 1);
            beat_q     <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) state_q <= write_q ? WRITE : READ;
          else                  wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        READ: begin
          // First READ cycle fetches beat 0; afterwards each accepted beat prefetches the next.
          if (!rdata_valid_o) begin
            rdata_o       <= mem[idx];
            rdata_valid_o <= 1'b1;
            rdata_last_o  <= (beat_q == LAST_BEAT);
          end else if (rdata_ready_i) begin
            if (rdata_last_o) begin
              state_q       <= IDLE;
              rdata_valid_o <= 1'b0;
              rdata_last_o  <= 1'b0;
              beat_q        <= '0;
            end else begin
              beat_q       <= beat_nxt;
              rdata_o      <= mem[idx_nxt];
              rdata_last_o <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        WRITE: begin
          if (wdata_valid_i) begin
            if (beat_q == LAST_BEAT) begin
              state_q <= IDLE;
              wack_o  <= 1'b1;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_nxt;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: writebacks, refills with stalls,
// aliasing, back-to-back requests and reset abort, checked against a word model.
module tb_mem_burst_responder;

  localparam int OW  = 4;
  localparam int AW  = 10;
  localparam int LAT = 3;
  localparam int LS  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic [31:0] wdata_i;
  logic        wdata_valid_i;
  logic        wdata_ready_o;
  logic        wack_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        rdata_last_o;
  logic        rdata_ready_i;

  mem_burst_responder #(.OFFSET_WIDTH(OW), .MEM_AW(AW), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
    .req_ready_o(req_ready_o),
    .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
    .wack_o(wack_o),
    .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .rdata_last_o(rdata_last_o),
    .rdata_ready_i(rdata_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb_q[$];
  logic [31:0] model [0:(1<<AW)-1];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr, input int k);
    logic [31:0] t;
    t = (addr >> 2) & 32'hFFFF_FFFC;
    t = t + 32'(k);
    return int'(t & 32'((1 << AW) - 1));
  endfunction

  task automatic push(input logic [31:0] addr);
    for (int k = 0; k < LS; k++)
      sb_q.push_back('{data: model[widx(addr, k)], last: logic'(k == LS - 1)});
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready",   32'(req_ready_o),   32'd1);
    check("rst_wdata_ready", 32'(wdata_ready_o), 32'd0);
    check("rst_wack",        32'(wack_o),        32'd0);
    check("rst_rvalid",      32'(rdata_valid_o), 32'd0);
    check("rst_rlast",       32'(rdata_last_o),  32'd0);
    check("rst_rdata",       rdata_o,            32'd0);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input bit hold);
    check("req_ready_idle", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    if (!wr) push(addr);
    step();
    if (!hold) req_valid_i = 1'b0;
    check("req_accepted", 32'(req_ready_o), 32'd0);
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!rdata_valid_o && n < 20) begin
      step();
      n++;
    end
    check("rvalid_latency", 32'(n), 32'(LAT + 1));
  endtask

  task automatic run_read(input int stall_beat, input int stall_n);
    int          beats = 0;
    int          stalled = 0;
    int          cyc = 0;
    logic [31:0] held = '0;
    beat_t       b;
    rdata_ready_i = 1'b1;
    while (beats < LS && cyc < 40) begin
      if (rdata_valid_o) begin
        if (beats == stall_beat && stalled < stall_n) begin
          if (stalled == 0) held = rdata_o;
          else check("stall_hold", rdata_o, held);
          rdata_ready_i = 1'b0;
          stalled++;
        end else begin
          if (beats == stall_beat) check("stall_release", rdata_o, held);
          rdata_ready_i = 1'b1;
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            b = sb_q.pop_front();
            check("rdata", rdata_o, b.data);
            check("rdata_last", 32'(rdata_last_o), 32'(b.last));
          end
          beats++;
        end
      end
      step();
      cyc++;
    end
    rdata_ready_i = 1'b1;
    check("read_beats", 32'(beats), 32'(LS));
    check("read_end_valid", 32'(rdata_valid_o), 32'd0);
    check("read_end_last", 32'(rdata_last_o), 32'd0);
    check("read_end_ready", 32'(req_ready_o), 32'd1);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] w0,
                           input bit toggle, input int nwords);
    int n = 0;
    int k = 0;
    int cyc = 0;
    int early = 0;
    bit v = 1'b1;
    while (!wdata_ready_o && n < 20) begin
      step();
      n++;
    end
    check("wready_latency", 32'(n), 32'(LAT));
    while (k < nwords && cyc < 40) begin
      wdata_valid_i = toggle ? v : 1'b1;
      wdata_i = wdata_valid_i ? w0 + 32'(k) : 32'hDEAD_BEEF;
      if (wdata_ready_o && wdata_valid_i) begin
        model[widx(addr, k)] = w0 + 32'(k);
        k++;
      end
      v = !v;
      step();
      cyc++;
      if (k < LS && (wack_o || req_ready_o)) early++;
    end
    wdata_valid_i = 1'b0;
    check("write_count", 32'(k), 32'(nwords));
    check("no_early_done", 32'(early), 32'd0);
  endtask

  task automatic wb_done();
    check("wack_pulse", 32'(wack_o), 32'd1);
    check("ready_with_wack", 32'(req_ready_o), 32'd1);
    step();
    check("wack_one_cycle", 32'(wack_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i = '0;
    wdata_i = '0;
    wdata_valid_i = 1'b0;
    rdata_ready_i = 1'b1;
    step();
    step();
    check_reset_outputs();
    rst_i = 1'b0;
    step();

    // Writeback of line 0x100, continuous data.
    issue(1'b1, 32'h100, 1'b0);
    run_write(32'h100, 32'hA0, 1'b0, LS);
    wb_done();

    // Refill from an unaligned address in the same line.
    issue(1'b0, 32'h10C, 1'b0);
    wait_rvalid();
    run_read(-1, 0);

    // Same refill with a two-cycle stall on beat 1.
    issue(1'b0, 32'h10C, 1'b0);
    wait_rvalid();
    run_read(1, 2);

    // Write data while idle must be ignored.
    wdata_valid_i = 1'b1;
    wdata_i = 32'hFF;
    repeat (3) begin
      check("idle_wready", 32'(wdata_ready_o), 32'd0);
      check("idle_no_wack", 32'(wack_o), 32'd0);
      step();
    end
    wdata_valid_i = 1'b0;

    // 0x1100 aliases 0x100 in a 1K-word memory; contents must still be A0..A3.
    issue(1'b0, 32'h1100, 1'b0);
    wait_rvalid();
    run_read(-1, 0);

    // Toggling writeback with a follow-on read request held high throughout.
    issue(1'b1, 32'h300, 1'b1);
    req_write_i = 1'b0;
    run_write(32'h300, 32'hD0, 1'b1, LS);
    check("wack_pulse_held", 32'(wack_o), 32'd1);
    check("ready_in_wack_cycle", 32'(req_ready_o), 32'd1);
    push(32'h300);
    step();
    req_valid_i = 1'b0;
    check("accept_after_wack", 32'(req_ready_o), 32'd0);
    check("wack_one_cycle_held", 32'(wack_o), 32'd0);
    wait_rvalid();
    run_read(-1, 0);

    // Full line at 0x200, then a partial overwrite aborted by reset.
    issue(1'b1, 32'h200, 1'b0);
    run_write(32'h200, 32'hB0, 1'b0, LS);
    wb_done();
    issue(1'b1, 32'h200, 1'b0);
    run_write(32'h200, 32'hC0, 1'b0, 2);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs();
    step();
    check("no_wack_after_abort", 32'(wack_o), 32'd0);
    rst_i = 1'b0;
    step();
    check("no_wack_after_release", 32'(wack_o), 32'd0);
    issue(1'b0, 32'h200, 1'b0);
    wait_rvalid();
    run_read(-1, 0);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
